// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader that fills instruction memory and releases the CPU
//
// Purpose:
//   Receives a little-endian 16-bit word count N followed by N little-endian
//   32-bit instruction words on a valid/ready byte stream, writes each word to
//   instruction memory at BASE_ADDR + index, then releases the processor from
//   reset. Oversized images (N > 2^ADDR_W - BASE_ADDR) end in a terminal error.
//
// Optional feature:
//   LOADER_CHECKSUM_EN - when defined, a running XOR of every data byte is kept
//   and one trailing checksum byte is accepted after the last word; a mismatch
//   ends in the error state. When undefined, no trailing byte is consumed.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_data    in   8       load-stream byte
//   in_valid   in   1       in_data valid
//   in_ready   out  1       loader accepts a byte this cycle
//   imem_we    out  1       instruction-memory write strobe
//   imem_addr  out  ADDR_W  instruction-memory word address
//   imem_wdata out  32      instruction word
//   cpu_rst    out  1       holds the processor in reset until the load is done
//   done       out  1       load complete
//   err        out  1       load failed

module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] ST_LEN0  = 3'd0;
  localparam logic [2:0] ST_LEN1  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK   = 3'd4;
  // Where the load goes once all words are written (or N=0).
  localparam logic [2:0] ST_END   = ST_CHK;
`else
  localparam logic [2:0] ST_END   = ST_DONE;
`endif

  // Largest word count that still fits between BASE_ADDR and the top of memory.
  // Kept 33 bits wide so the comparison against a 16-bit count never truncates.
  localparam logic [32:0]       MAX_WORDS = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE_W    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [2:0]        state_q,    state_d;
  logic [15:0]       len_q,      len_d;
  logic [15:0]       idx_q,      idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q,     word_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q,      chk_d;
`endif

  logic        xfer;
  logic [15:0] len_full;

  // Ready is a pure decode of the state so a stalled sender sees a stable value.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_LEN0, ST_LEN1, ST_DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:                    in_ready = 1'b1;
`endif
      default:                   in_ready = 1'b0;
    endcase
  end

  assign xfer     = in_valid & in_ready;
  // Full count as it will look once the high byte in LEN1 is taken.
  assign len_full = {in_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      ST_LEN0: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          if ({17'd0, len_full} > MAX_WORDS) begin
            state_d = ST_ERR;
          end else if (len_full == 16'd0) begin
            state_d = ST_END;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          // First byte of the word lands in bits 7:0.
          word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // Address and index advance together; the limit check in LEN1
        // guarantees the address never has to wrap past the top of memory.
        idx_d   = idx_q + 16'd1;
        addr_d  = addr_q + ADDR_ONE;
        state_d = (idx_d < len_q) ? ST_DATA : ST_END;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          state_d = (in_data == chk_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      // Unused encodings fail safe: the CPU stays in reset.
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LEN0;
      len_q      <= 16'd0;
      idx_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      addr_q     <= BASE_W;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign cpu_rst    = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL provide parameter BASE_ADDR, default 0, first word address written.
REQ-003 SHALL provide the following ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  load-stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts byte this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  instruction word.
- cpu_rst  output  1  holds processor pipeline in reset.
- done  output  1  load complete.
- err  output  1  load failed.

Function
REQ-004 SHALL define a byte transfer as in_valid=1 and in_ready=1 on the same rising edge; no other byte is consumed.
REQ-005 SHALL implement states LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR; reset state LEN0.
REQ-006 SHALL drive in_ready=1 only in LEN0, LEN1, DATA and CHK.
REQ-007 LEN0/LEN1 SHALL capture the 16-bit word count N little-endian (low byte first); LEN0->LEN1 on transfer.
REQ-008 LEN1 on transfer SHALL go to ERR if N > 2^ADDR_W - BASE_ADDR, else to DONE/CHK if N=0, else to DATA.
REQ-009 DATA SHALL assemble four bytes little-endian (first byte = bits 7:0); after the fourth transfer it SHALL go to WRITE.
REQ-010 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=BASE_ADDR+idx (modulo 2^ADDR_W), imem_wdata=assembled word; idx then increments.
REQ-011 After WRITE SHALL go to DATA if idx < N, else to CHK (macro defined) or DONE.
REQ-012 imem_we SHALL be 1 only in WRITE; imem_addr/imem_wdata are don't-care when imem_we=0 but SHALL not contain X after reset.
REQ-013 cpu_rst SHALL be 1 in every state except DONE; done=1 only in DONE; err=1 only in ERR.
REQ-014 DONE and ERR SHALL be terminal until rst; bytes presented there are not consumed.
REQ-015 Latency: first imem_we SHALL assert the cycle after the sixth accepted byte; each subsequent word needs 4 transfers + 1 cycle.
REQ-016 in_valid held low SHALL stall any receiving state indefinitely with no state change.

Reset
REQ-017 rst=1 SHALL, at the next edge, set state LEN0, idx=0, N=0, byte counter=0, checksum=0, imem_we=0, cpu_rst=1, done=0, err=0, in_ready=1, imem_addr=BASE_ADDR, imem_wdata=0.
REQ-018 rst mid-load SHALL discard any partial word and count; words already written to memory are not cleared.

Configuration
REQ-019 With LOADER_CHECKSUM_EN defined: running XOR of all DATA bytes (length bytes excluded) is kept; CHK accepts one byte and goes to DONE if equal, ERR otherwise.
REQ-020 Without LOADER_CHECKSUM_EN: CHK state and XOR register absent; transitions that target CHK go to DONE directly; no trailing byte is consumed.

Verification
REQ-021 Stream 01 00 13 05 A0 00 -> single imem_we, addr 0, wdata 0x00A00513; cpu_rst falls and done rises one cycle later (no macro).
REQ-022 N=3 with in_valid toggling every other cycle -> writes at addr 0,1,2 in order, data intact, in_ready low during each WRITE cycle.
REQ-023 Length bytes 01 04 (N=1025) with ADDR_W=10 -> ERR after second byte, err=1, cpu_rst=1, no imem_we, further bytes not accepted.
REQ-024 LOADER_CHECKSUM_EN defined, stream 01 00 13 05 A0 00 B6 -> DONE; same with trailing B7 -> ERR.
REQ-025 rst pulsed after 2 data bytes, then full stream 01 00 EF BE AD DE -> exactly one write, wdata 0xDEADBEEF, addr 0.
REQ-026 Length bytes 00 00 -> DONE the cycle after the second byte (macro undefined), no imem_we.
